// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 definitions for the write responder and its address generator:
// burst-type and response encodings, the responder state enum, the 4KB page
// geometry and a helper that says whether a WRAP length is legal.
// No ports (package).
// ---------------------------------------------------------------------------
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam int PAGE_SHIFT = 12;
   localparam int PAGE_BYTES = 1 << PAGE_SHIFT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } wslv_state_t;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_legal(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Purely combinational AXI4 next-beat address calculator, shared with any
// future read responder.
// Ports:
//   addr      in   current beat address
//   len       in   burst length minus one
//   size      in   log2 bytes per beat
//   burst     in   burst type (FIXED/INCR/WRAP, reserved treated as INCR)
//   next_addr out  address of the following beat (modulo 2^AW)
//   wrap_ok   out  len is a legal WRAP length
// An illegal-length WRAP advances like INCR so callers need no special case.
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr,
   input  logic [7:0]    len,
   input  logic [2:0]    size,
   input  logic [1:0]    burst,
   output logic [AW-1:0] next_addr,
   output logic          wrap_ok
);

   logic [AW-1:0] step;
   logic [AW-1:0] incr_addr;
   logic [AW-1:0] wrap_mask;

   // The wrap window is (len+1)<<size bytes and naturally aligned, so the
   // high bits come from the current address and the low bits from the
   // incremented address.
   always_comb begin
      step      = AW'(1) << size;
      incr_addr = addr + step;
      wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
      wrap_ok   = wrap_len_legal(len);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                          : incr_addr;
         default:     next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_write_slave.sv
// ---------------------------------------------------------------------------
// axi_write_slave
// AXI4 write-channel responder: accepts one AW burst at a time, absorbs its
// W beats, presents each beat on a single-cycle memory write port and
// returns one B response per burst.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   axi_aw*                    write address channel (addr/len/size/burst)
//   axi_w*                     write data channel (data/strb/last)
//   axi_b*                     write response channel
//   mem_we/addr/wdata/wstrb    registered one-cycle memory write per beat
// Optional build macro AXI_WSLV_RANGE_CHECK_EN: decode AW addresses against
// [BASE_ADDR, BASE_ADDR+MEM_BYTES), answer DECERR with writes suppressed for
// out-of-range bursts, and present mem_addr relative to BASE_ADDR.
// ---------------------------------------------------------------------------
module axi_write_slave
   import axi_pkg::*;
#(
   parameter int            AW        = 32,
   parameter int            DW        = 64,
   parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [AW-1:0] MEM_BYTES = 32'h0001_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   axi_awaddr,
   input  logic [7:0]      axi_awlen,
   input  logic [2:0]      axi_awsize,
   input  logic [1:0]      axi_awburst,
   input  logic            axi_awvalid,
   output logic            axi_awready,
   input  logic [DW-1:0]   axi_wdata,
   input  logic [DW/8-1:0] axi_wstrb,
   input  logic            axi_wlast,
   input  logic            axi_wvalid,
   output logic            axi_wready,
   output logic [1:0]      axi_bresp,
   output logic            axi_bvalid,
   input  logic            axi_bready,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));

   wslv_state_t   state_q, state_d;
   logic          awready_d, wready_d, bvalid_d;
   logic [1:0]    bresp_d;

   logic [AW-1:0] addr_q;
   logic [7:0]    len_q;
   logic [2:0]    size_q;
   logic [1:0]    burst_q;
   logic [7:0]    beat_cnt;
   logic          err_q;
   logic          dec_err_q;
   logic          suppress_q;

   logic          aw_fire, w_fire, last_beat;
   logic          aw_reserved, aw_bad_wrap, aw_too_wide, aw_out_of_range;
   logic [1:0]    aw_burst_eff;
   logic [AW-1:0] next_addr;
   logic          wrap_ok;
   logic          eff_incr, page_cross, beat_err;
   logic [AW-1:0] beat_mem_addr;

   axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
      .addr      (addr_q),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr),
      .wrap_ok   (wrap_ok)
   );

   assign aw_fire   = axi_awvalid & axi_awready;
   assign w_fire    = axi_wvalid & axi_wready;
   assign last_beat = (beat_cnt == len_q);

   // Burst classification at AW time. Reserved bursts are latched as INCR;
   // an illegal WRAP is latched as WRAP and the generator advances it as INCR.
   always_comb begin
      aw_reserved  = (axi_awburst == 2'd3);
      aw_bad_wrap  = (axi_awburst == BURST_WRAP) && !wrap_len_legal(axi_awlen);
      aw_too_wide  = (axi_awsize > MAX_SIZE);
      aw_burst_eff = aw_reserved ? BURST_INCR : axi_awburst;
   end

`ifdef AXI_WSLV_RANGE_CHECK_EN
   // Subtract before comparing so a region ending at 2^AW cannot overflow.
   assign aw_out_of_range = (axi_awaddr < BASE_ADDR) || ((axi_awaddr - BASE_ADDR) >= MEM_BYTES);
   assign beat_mem_addr   = addr_q - BASE_ADDR;
`else
   logic unused_range_cfg;
   assign unused_range_cfg = ^{BASE_ADDR, MEM_BYTES};
   assign aw_out_of_range  = 1'b0;
   assign beat_mem_addr    = addr_q;
`endif

   // A 4KB crossing only matters when another beat follows in the new page.
   always_comb begin
      eff_incr   = (burst_q == BURST_INCR) || ((burst_q == BURST_WRAP) && !wrap_ok);
      page_cross = eff_incr && !last_beat &&
                   (next_addr[AW-1:PAGE_SHIFT] != addr_q[AW-1:PAGE_SHIFT]);
      beat_err   = (axi_wlast != last_beat) || page_cross;
   end

   // FSM state and the registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         axi_awready <= 1'b0;
         axi_wready  <= 1'b0;
         axi_bvalid  <= 1'b0;
         axi_bresp   <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         axi_awready <= awready_d;
         axi_wready  <= wready_d;
         axi_bvalid  <= bvalid_d;
         axi_bresp   <= bresp_d;
      end
   end

   // Next state and next handshake outputs. The response is resolved on the
   // final beat so it already includes that beat's own error.
   always_comb begin
      state_d   = state_q;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b0;
      bresp_d   = axi_bresp;
      case (state_q)
         IDLE: begin
            if (aw_fire) begin
               state_d  = DATA;
               wready_d = 1'b1;
            end else begin
               awready_d = 1'b1;
            end
         end
         DATA: begin
            if (w_fire && last_beat) begin
               state_d  = RESP;
               bvalid_d = 1'b1;
               if (dec_err_q)
                  bresp_d = RESP_DECERR;
               else if (err_q || beat_err)
                  bresp_d = RESP_SLVERR;
               else
                  bresp_d = RESP_OKAY;
            end else begin
               wready_d = 1'b1;
            end
         end
         RESP: begin
            if (axi_bready) begin
               state_d   = IDLE;
               awready_d = 1'b1;
               bresp_d   = RESP_OKAY;
            end else begin
               bvalid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst context, beat counter, sticky errors and the memory write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= BURST_INCR;
         beat_cnt   <= '0;
         err_q      <= 1'b0;
         dec_err_q  <= 1'b0;
         suppress_q <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
      end else begin
         mem_we <= 1'b0;
         if (aw_fire) begin
            addr_q     <= axi_awaddr;
            len_q      <= axi_awlen;
            size_q     <= axi_awsize;
            burst_q    <= aw_burst_eff;
            beat_cnt   <= '0;
            err_q      <= aw_reserved || aw_bad_wrap || aw_too_wide;
            dec_err_q  <= aw_out_of_range;
            suppress_q <= aw_too_wide || aw_out_of_range;
         end
         if (w_fire) begin
            mem_we    <= !suppress_q;
            mem_addr  <= beat_mem_addr;
            mem_wdata <= axi_wdata;
            mem_wstrb <= axi_wstrb;
            addr_q    <= next_addr;
            beat_cnt  <= beat_cnt + 8'd1;
            err_q     <= err_q || beat_err;
         end
      end
   end

endmodule

// File: tb/tb_axi_write_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_write_slave
// Directed self-checking bench for axi_write_slave with default parameters
// (AW=32, DW=64, BASE_ADDR=0, MEM_BYTES=0x10000). Honours the optional
// AXI_WSLV_RANGE_CHECK_EN build macro.
// ---------------------------------------------------------------------------
module tb_axi_write_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] axi_awaddr;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [63:0] axi_wdata;
   logic [7:0]  axi_wstrb;
   logic        axi_wlast;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;

   int checks   = 0;
   int failures = 0;
   int burst_id = 0;

   logic [31:0] exp_addr [$];
   logic [63:0] exp_data [$];
   logic [31:0] got_addr [$];
   logic [63:0] got_data [$];
   logic [7:0]  got_strb [$];

   axi_write_slave dut (
      .clk         (clk),
      .reset       (reset),
      .axi_awaddr  (axi_awaddr),
      .axi_awlen   (axi_awlen),
      .axi_awsize  (axi_awsize),
      .axi_awburst (axi_awburst),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wlast   (axi_wlast),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb)
   );

   always #5 clk = ~clk;

   // Record every memory write in order, sampled before the edge updates it.
   always @(posedge clk) begin
      if (mem_we) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_wdata);
         got_strb.push_back(mem_wstrb);
      end
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One complete burst: AW handshake, len+1 W beats, optional bready stall,
   // then comparison of the captured writes against exp_addr/exp_data.
   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int wlast_beat,
                                input logic [7:0] strb, input int bready_delay, input logic [1:0] exp_resp);
      int waits;
      logic [63:0] d;
      got_addr.delete();
      got_data.delete();
      got_strb.delete();
      exp_data.delete();
      axi_awaddr  = addr;
      axi_awlen   = len;
      axi_awsize  = size;
      axi_awburst = burst;
      axi_awvalid = 1'b1;
      waits = 0;
      while (!axi_awready && waits < 20) begin
         tick();
         waits++;
      end
      checkOutput({tag, ".awready"}, 64'(axi_awready), 64'd1);
      tick();
      axi_awvalid = 1'b0;
      checkOutput({tag, ".awready_low"}, 64'(axi_awready), 64'd0);
      checkOutput({tag, ".wready"}, 64'(axi_wready), 64'd1);
      for (int b = 0; b <= int'(len); b++) begin
         d = {16'hDA7A, 16'(burst_id), 32'(b)};
         axi_wdata  = d;
         axi_wstrb  = strb;
         axi_wlast  = (b == wlast_beat);
         axi_wvalid = 1'b1;
         exp_data.push_back(d);
         tick();
      end
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
      checkOutput({tag, ".bvalid_latency"}, 64'(axi_bvalid), 64'd1);
      checkOutput({tag, ".bresp"}, 64'(axi_bresp), 64'(exp_resp));
      for (int s = 0; s < bready_delay; s++) begin
         tick();
         checkOutput({tag, ".bvalid_hold"}, 64'(axi_bvalid), 64'd1);
         checkOutput({tag, ".bresp_hold"}, 64'(axi_bresp), 64'(exp_resp));
         checkOutput({tag, ".awready_stall"}, 64'(axi_awready), 64'd0);
      end
      axi_bready = 1'b1;
      tick();
      axi_bready = 1'b0;
      checkOutput({tag, ".bvalid_clear"}, 64'(axi_bvalid), 64'd0);
      checkOutput({tag, ".awready_back"}, 64'(axi_awready), 64'd1);
      checkOutput({tag, ".writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         checkOutput($sformatf("%s.addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
         checkOutput($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
         checkOutput($sformatf("%s.strb%0d", tag, i), 64'(got_strb[i]), 64'(strb));
      end
      burst_id++;
   endtask

   initial begin
      reset       = 1'b1;
      axi_awaddr  = '0;
      axi_awlen   = '0;
      axi_awsize  = '0;
      axi_awburst = '0;
      axi_awvalid = 1'b0;
      axi_wdata   = '0;
      axi_wstrb   = '0;
      axi_wlast   = 1'b0;
      axi_wvalid  = 1'b0;
      axi_bready  = 1'b0;
      tick();
      tick();
      checkOutput("rst.awready", 64'(axi_awready), 64'd0);
      checkOutput("rst.wready", 64'(axi_wready), 64'd0);
      checkOutput("rst.bvalid", 64'(axi_bvalid), 64'd0);
      checkOutput("rst.bresp", 64'(axi_bresp), 64'd0);
      checkOutput("rst.mem_we", 64'(mem_we), 64'd0);
      checkOutput("rst.mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b0;
      tick();
      checkOutput("rst.awready_after", 64'(axi_awready), 64'd1);

      exp_addr = '{32'h100, 32'h108, 32'h110, 32'h118};
      applyStimulus("incr", 32'h100, 8'd3, 3'd3, 2'd1, 3, 8'hFF, 0, 2'd0);

      exp_addr = '{32'h118, 32'h100, 32'h108, 32'h110};
      applyStimulus("wrap", 32'h118, 8'd3, 3'd3, 2'd2, 3, 8'hFF, 0, 2'd0);

      exp_addr = '{32'h40, 32'h40, 32'h40};
      applyStimulus("fixed", 32'h40, 8'd2, 3'd3, 2'd0, 2, 8'h0F, 0, 2'd0);

      exp_addr = '{32'h500, 32'h508, 32'h510, 32'h518};
      applyStimulus("early_wlast", 32'h500, 8'd3, 3'd3, 2'd1, 1, 8'hFF, 0, 2'd2);

      exp_addr = '{32'h600};
      applyStimulus("bstall", 32'h600, 8'd0, 3'd3, 2'd1, 0, 8'h3C, 5, 2'd0);

      exp_addr = '{32'h300, 32'h304};
      applyStimulus("reserved", 32'h300, 8'd1, 3'd2, 2'd3, 1, 8'h0F, 0, 2'd2);

      exp_addr = '{32'h118, 32'h120, 32'h128};
      applyStimulus("bad_wrap", 32'h118, 8'd2, 3'd3, 2'd2, 2, 8'hFF, 0, 2'd2);

      exp_addr.delete();
      applyStimulus("too_wide", 32'h400, 8'd1, 3'd4, 2'd1, 1, 8'hFF, 0, 2'd2);

      exp_addr = '{32'hFF8, 32'h1000};
      applyStimulus("page_cross", 32'hFF8, 8'd1, 3'd3, 2'd1, 1, 8'hFF, 0, 2'd2);

      // Reset in the middle of an 8-beat burst.
      axi_awaddr  = 32'h700;
      axi_awlen   = 8'd7;
      axi_awsize  = 3'd3;
      axi_awburst = 2'd1;
      axi_awvalid = 1'b1;
      tick();
      axi_awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         axi_wdata  = 64'(b);
         axi_wstrb  = 8'hFF;
         axi_wvalid = 1'b1;
         tick();
      end
      checkOutput("rst_mid.pre_we", 64'(mem_we), 64'd1);
      checkOutput("rst_mid.pre_addr", 64'(mem_addr), 64'h708);
      reset      = 1'b1;
      axi_wvalid = 1'b0;
      #1;
      checkOutput("rst_mid.mem_we", 64'(mem_we), 64'd0);
      checkOutput("rst_mid.mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst_mid.mem_wdata", mem_wdata, 64'd0);
      checkOutput("rst_mid.wready", 64'(axi_wready), 64'd0);
      checkOutput("rst_mid.awready", 64'(axi_awready), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("rst_mid.bvalid", 64'(axi_bvalid), 64'd0);
      end
      reset = 1'b0;
      tick();
      checkOutput("rst_mid.awready_after", 64'(axi_awready), 64'd1);
      checkOutput("rst_mid.bvalid_after", 64'(axi_bvalid), 64'd0);

      exp_addr = '{32'h800, 32'h808};
      applyStimulus("post_rst", 32'h800, 8'd1, 3'd3, 2'd1, 1, 8'hAA, 0, 2'd0);

`ifdef AXI_WSLV_RANGE_CHECK_EN
      exp_addr.delete();
      applyStimulus("decerr", 32'h0001_0000, 8'd1, 3'd3, 2'd1, 1, 8'hFF, 0, 2'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
